// File: rtl/frame_arbiter.sv
// Round-robin framer: grants one channel per frame and emits HEADER, channel id,
// up to MAX_BURST data words and FOOTER on a registered valid/ready byte link.
module frame_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter logic [7:0]  HEADER    = 8'hAA,
  parameter logic [7:0]  FOOTER    = 8'hFF,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned TIMEOUT   = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [7:0]                dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      busy
);

  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BCW = $clog2(MAX_BURST + 1);
  localparam int unsigned ICW = $clog2(TIMEOUT + 1);

  // State names the next byte to be loaded onto the link.
  typedef enum logic [1:0] {
    S_IDLE,
    S_CHID,
    S_DATA,
    S_FOOTER
  } state_t;

  state_t         state_q;
  logic [IDW-1:0] winner_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [BCW-1:0] burst_q;
  logic [ICW-1:0] idle_q;
  logic [7:0]     dout_q;
  logic           valid_q;

  logic           load_en;
  logic           pick_vld_d;
  logic [IDW-1:0] pick_d;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] rr_next_d;
  logic           win_req;
  logic [7:0]     win_data;
  logic [BCW-1:0] burst_inc;
  logic [ICW-1:0] idle_inc;

  assign load_en   = !valid_q || dout_ready;
  assign win_req   = req[winner_q];
  assign win_data  = req_data[32'(winner_q)*DATA_W +: 8];
  assign burst_inc = burst_q + BCW'(1);
  assign idle_inc  = idle_q + ICW'(1);
  assign rr_next_d = (winner_q == IDW'(NUM_REQ - 1)) ? '0 : winner_q + IDW'(1);

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_d     = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!pick_vld_d && req[cand]) begin
        pick_vld_d = 1'b1;
        pick_d     = cand;
      end
    end
  end

  // Pop is tied to the very edge that loads the word, so it is combinational.
  always_comb begin
    grant = '0;
    if (!rst && load_en && (state_q == S_DATA) && win_req) begin
      grant[winner_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      winner_q <= '0;
      rr_ptr_q <= '0;
      burst_q  <= '0;
      idle_q   <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else if (load_en) begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld_d) begin
            winner_q <= pick_d;
            dout_q   <= HEADER;
            valid_q  <= 1'b1;
            state_q  <= S_CHID;
          end else begin
            valid_q  <= 1'b0;
          end
        end
        S_CHID: begin
          dout_q  <= 8'(winner_q);
          valid_q <= 1'b1;
          burst_q <= '0;
          idle_q  <= '0;
          state_q <= S_DATA;
        end
        S_DATA: begin
          if (win_req) begin
            dout_q  <= win_data;
            valid_q <= 1'b1;
            burst_q <= burst_inc;
            idle_q  <= '0;
            if (burst_inc == BCW'(MAX_BURST)) state_q <= S_FOOTER;
          end else begin
            valid_q <= 1'b0;
            idle_q  <= idle_inc;
            if (idle_inc == ICW'(TIMEOUT)) state_q <= S_FOOTER;
          end
        end
        S_FOOTER: begin
          dout_q   <= FOOTER;
          valid_q  <= 1'b1;
          rr_ptr_q <= rr_next_d;
          state_q  <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = (state_q != S_IDLE);

endmodule
